// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32 program-counter stage:
//   XLEN          datapath / PC width
//   state_t       fetch sequencer state encoding
//   RESET_PC_DEF  default PC loaded on reset
//   TRAP_VEC_DEF  default PC loaded on a misaligned redirect
//   ALIGN_MASK    low address bits that must be zero for a word fetch
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC_DEF = 32'h0000_0100;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Only the two low address bits decide word alignment.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Bundles the fetch stage's bus-facing signals.
//   master : the fetch unit (drives pc, imem_req, instr_valid, misalign,
//            trap_addr; receives adder sum, memory ready, stall, redirects)
//   slave  : the surrounding core / instruction memory
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int XLEN = core_pkg::XLEN
);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            imem_req;
    logic            imem_ready;
    logic            instr_valid;
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump_valid;
    logic [XLEN-1:0] jump_target;
    logic            misalign;
    logic [XLEN-1:0] trap_addr;

    modport master (
        output pc,
        output imem_req,
        output instr_valid,
        output misalign,
        output trap_addr,
        input  pc_plus4,
        input  imem_ready,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump_valid,
        input  jump_target
    );

    modport slave (
        input  pc,
        input  imem_req,
        input  instr_valid,
        input  misalign,
        input  trap_addr,
        output pc_plus4,
        output imem_ready,
        output stall,
        output branch_taken,
        output branch_target,
        output jump_valid,
        output jump_target
    );
endinterface

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// ---------------------------------------------------------------------------
// next_pc_mux
// Combinational next-PC priority select with misalignment detect.
// Ports:
//   i_pc_plus4        sum from the datapath adder (sequential successor)
//   i_branch_taken    conditional branch resolved taken
//   i_branch_target   branch destination
//   i_jump_valid      JAL/JALR redirect
//   i_jump_target     jump destination
//   o_next_pc         jump > branch > pc_plus4
//   o_redirect_target selected redirect destination (jump over branch)
//   o_misaligned      a redirect is selected and its target is not word aligned
// ---------------------------------------------------------------------------
module next_pc_mux
    import core_pkg::*;
(
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic            i_branch_taken,
    input  logic [XLEN-1:0] i_branch_target,
    input  logic            i_jump_valid,
    input  logic [XLEN-1:0] i_jump_target,
    output logic [XLEN-1:0] o_next_pc,
    output logic [XLEN-1:0] o_redirect_target,
    output logic            o_misaligned
);

    logic w_redirect;

    always_comb begin
        w_redirect        = i_jump_valid | i_branch_taken;
        // A simultaneous branch is dropped: the jump is older in program order.
        o_redirect_target = i_jump_valid ? i_jump_target : i_branch_target;
        o_next_pc         = w_redirect ? o_redirect_target : i_pc_plus4;
        // The sequential path is never checked; pc stays aligned by construction.
        o_misaligned      = w_redirect & ~is_word_aligned(o_redirect_target[1:0]);
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter stage of the single-cycle RV32 core. Holds the PC, paces
// fetch with a req/ready handshake plus downstream stall, and redirects to a
// trap vector on a misaligned jump/branch target.
// Ports:
//   i_clk   core clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     pc_fetch_unit_if.master (pc, pc_plus4, imem_req/ready,
//           instr_valid, stall, branch/jump redirects, misalign, trap_addr)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_BOOT  | dead cycle after reset, no request
// S_FETCH | requesting pc; advance when memory ready and no stall
// S_STALL | word returned but decode stalled; re-fetch pc once released
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    pc_fetch_unit_if.master bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            r_misalign;
    logic [XLEN-1:0] r_trap_addr;

    logic            w_advance;
    logic            w_imem_req;
    logic            w_instr_valid;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_misaligned;

    next_pc_mux u_next_pc_mux (
        .i_pc_plus4        (bus.pc_plus4),
        .i_branch_taken    (bus.branch_taken),
        .i_branch_target   (bus.branch_target),
        .i_jump_valid      (bus.jump_valid),
        .i_jump_target     (bus.jump_target),
        .o_next_pc         (w_next_pc),
        .o_redirect_target (w_redirect_target),
        .o_misaligned      (w_misaligned)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_advance     = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req    = 1'b1;
                w_instr_valid = bus.imem_ready;
                if (bus.imem_ready && !bus.stall) begin
                    w_advance = 1'b1;
                end else if (bus.imem_ready && bus.stall) begin
                    w_state_nxt = S_STALL;
                end
            end
            S_STALL: begin
                if (!bus.stall) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // PC and sticky trap record; redirect inputs matter only on an advance.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc        <= RESET_PC;
            r_misalign  <= 1'b0;
            r_trap_addr <= '0;
        end else if (w_advance) begin
            if (w_misaligned) begin
                r_pc       <= TRAP_VEC;
                r_misalign <= 1'b1;
                if (!r_misalign) begin
                    r_trap_addr <= w_redirect_target;
                end
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Handshake outputs are forced low while reset is held so a mid-fetch
    // reset never presents a stale request.
    assign bus.imem_req    = w_imem_req & ~i_rst;
    assign bus.instr_valid = w_instr_valid & ~i_rst;
    assign bus.pc          = r_pc;
    assign bus.misalign    = r_misalign;
    assign bus.trap_addr   = r_trap_addr;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-cycle RV32 core. Holds the architectural PC, drives it to instruction memory and to the datapath's PC+4 adder, and takes the adder's sum back as the sequential next PC.
- Selects the next PC from jump, branch or PC+4, and paces fetch with a req/ready handshake and a stall input.
- Redirects to a trap vector on misaligned targets.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  out  XLEN  current PC, to instruction memory address and adder data1.
- pc_plus4  in  XLEN  adder sum (pc + 4), settled before the edge.
- imem_req  out  1  fetch request for address pc.
- imem_ready  in  1  instruction memory returns the word at pc this cycle.
- instr_valid  out  1  fetched instruction valid to decode this cycle.
- stall  in  1  downstream cannot accept an instruction.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  XLEN  branch destination.
- jump_valid  in  1  JAL/JALR redirect.
- jump_target  in  XLEN  jump destination (JALR LSB already cleared upstream).
- misalign  out  1  sticky: a misaligned redirect occurred.
- trap_addr  out  XLEN  offending target of the first misaligned redirect.

Behaviour:
- Reset (rst=1 at edge, from any state, mid-handshake included) sets:
  - pc=RESET_PC, state=S_BOOT, misalign=0, trap_addr=0.
  - Outputs during and right after reset: imem_req=0, instr_valid=0.
- States:
  - S_BOOT: imem_req=0. Goes to S_FETCH next cycle unconditionally (one dead cycle after reset).
  - S_FETCH: imem_req=1. instr_valid = imem_ready (combinational). advance = imem_ready & ~stall.
    - advance=1: pc <= next_pc, stay in S_FETCH.
    - imem_ready=1 & stall=1: pc holds, go to S_STALL.
    - imem_ready=0: pc holds, stay. Redirect inputs are ignored.
  - S_STALL: imem_req=0, instr_valid=0, pc holds, redirect inputs are ignored. When stall=0, go to S_FETCH and re-fetch the same pc.
- next_pc priority:
  - jump_valid → jump_target.
  - else branch_taken → branch_target.
  - else pc_plus4.
  - Redirect inputs are sampled only on the advance edge.
- Misalignment (selected redirect target[1:0] != 2'b00, on the advance edge):
  - pc <= TRAP_VEC; misalign <= 1 (sticky until rst).
  - trap_addr <= target, only if misalign was 0 (first fault wins).
  - pc_plus4 is never checked, since pc stays word-aligned by construction.
- Wrap-around: pc=32'hFFFF_FFFC with pc_plus4=0 advances to 0; no flag.
- Simultaneous jump_valid and branch_taken: jump wins; the branch is dropped silently.
- Widths:
  - All PC arithmetic is external (the adder), XLEN bits, modulo 2^XLEN.
  - The block performs no addition itself, only selection and registering.
- Every output is registered except imem_req and instr_valid, which decode state and imem_ready.

Decomposition:
- Shared package `core_pkg`:
  - XLEN.
  - State encoding S_BOOT=2'd0, S_FETCH=2'd1, S_STALL=2'd2.
  - RESET_PC/TRAP_VEC defaults.
  - ALIGN_MASK=2'b11.
- One natural sub-module: `next_pc_mux`, the combinational priority select plus misalign detect. It outputs next_pc, redirect_target and misaligned.
- The PC+4 incrementer stays the datapath's existing adder instance and is not duplicated here.

Test Plan:
- Reset then free run: rst=1 for 2 cycles, imem_ready=1, stall=0, pc_plus4 driven as pc+4.
  → pc=0 with imem_req=0 on the boot cycle, then pc sequence 0,4,8,C, with instr_valid=1 on each fetch cycle.
- Branch vs jump priority: at pc=0x10 assert branch_taken (target 0x40) and jump_valid (target 0x80) together → next pc=0x80. Repeat with branch only → pc=0x40.
- Memory wait and stall: at pc=0x20 hold imem_ready=0 for 3 cycles.
  → pc stays 0x20 and instr_valid=0.
  → On ready with stall=1: S_STALL, imem_req=0.
  → Release stall: re-fetch 0x20, then advance to 0x24.
- Misaligned redirect: jump_target=0x0000_0042 on advance → pc=0x100, misalign=1, trap_addr=0x42. A later branch_target=0x0000_0081 leaves trap_addr=0x42.
- Wrap and mid-operation reset:
  - From pc=0xFFFF_FFFC, advance → pc=0.
  - Assert rst while in S_STALL with stall=1 → next cycle pc=RESET_PC, state S_BOOT, misalign=0.
